// File: rtl/deci_bcd_pkg.sv
// Shared types and constants for the decimal key to BCD entry encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package deci_bcd_pkg;

    // Width of one BCD digit.
    localparam int BCD_W    = 4;

    // Number of decimal key lines (keys 0..9).
    localparam int NUM_KEYS = 10;

    // Key debounce state machine.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

endpackage

// File: rtl/deci_bcd_keyenc_if.sv
// Key-side bus of the BCD entry encoder: raw key lines and clear in, entry state out.
// Latency: n/a (wiring only).
// Backpressure: none; key acceptance is reported as a one-cycle pulse, with no ready.
interface deci_bcd_keyenc_if
    import deci_bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [NUM_KEYS-1:0]         d;
    logic                        clr;
    logic                        key_valid;
    logic [BCD_W-1:0]            key_code;
    logic [BCD_W*NUM_DIGITS-1:0] bcd_out;
    logic [CNT_W-1:0]            digit_cnt;
    logic                        full;
    logic                        overflow;

    // Keypad / controller side: drives keys and clear, observes the entry.
    modport master (
        output d, clr,
        input  key_valid, key_code, bcd_out, digit_cnt, full, overflow
    );

    // Encoder side.
    modport slave (
        input  d, clr,
        output key_valid, key_code, bcd_out, digit_cnt, full, overflow
    );

endinterface

// File: rtl/deci_prio_enc.sv
// Priority encoder for the 10 decimal key lines: the highest set index wins.
// Latency: combinational.
// Backpressure: none.
module deci_prio_enc
    import deci_bcd_pkg::*;
(
    input  logic [NUM_KEYS-1:0] i_d,
    output logic [BCD_W-1:0]    o_code,
    output logic                o_any
);

    // Walk upwards so that the last (highest) set line overwrites the lower ones.
    always_comb begin
        o_code = '0;
        o_any  = |i_d;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (i_d[i]) begin
                o_code = BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/deci_bcd_keyenc.sv
// Debounced decimal key encoder that shifts accepted keys into a packed BCD entry register.
// Latency: key_valid pulses in the cycle after the (DEBOUNCE_CYCLES+1)-th stable edge.
// Backpressure: none; build option DECI_BCD_ROLL_EN makes a full entry roll instead of hold.
module deci_bcd_keyenc
    import deci_bcd_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(NUM_DIGITS + 1)
) (
    input  logic clk,
    input  logic rst,
    deci_bcd_keyenc_if.slave bus
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ENT_W = BCD_W * NUM_DIGITS;

    // Debounce FSM state.
    state_t                r_state;
    logic [NUM_KEYS-1:0]   r_sample;
    logic [DB_W-1:0]       r_db_cnt;

    // Registered outputs.
    logic                  r_key_valid;
    logic [BCD_W-1:0]      r_key_code;
    logic [ENT_W-1:0]      r_bcd;
    logic [CNT_W-1:0]      r_digit_cnt;
    logic                  r_overflow;

    // Combinational helpers.
    logic [BCD_W-1:0]      w_code;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_full;
    logic [ENT_W-1:0]      w_shift;

    // At the accepting edge d equals the stored sample, so encoding the live
    // lines gives the same code as encoding the sample.
    deci_prio_enc u_prio_enc (
        .i_d    (bus.d),
        .o_code (w_code),
        .o_any  (w_any)
    );

    // A key is accepted when the sample has been seen DEBOUNCE_CYCLES times
    // already and the lines still match it at this edge.
    assign w_accept = (r_state == DEBOUNCE) &&
                      (bus.d == r_sample) &&
                      (r_db_cnt == DB_W'(DEBOUNCE_CYCLES));

    assign w_full = (r_digit_cnt == CNT_W'(NUM_DIGITS));

    // New digit enters at the bottom; the oldest digit falls off the top.
    generate
        if (NUM_DIGITS == 1) begin : g_shift_one
            assign w_shift = w_code;
        end else begin : g_shift_many
            assign w_shift = {r_bcd[ENT_W-BCD_W-1:0], w_code};
        end
    endgenerate

    // Debounce FSM: track the raw key pattern, pulse key_valid once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_db_cnt    <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sample <= bus.d;
                        r_db_cnt <= DB_W'(1);
                        r_state  <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (bus.d != r_sample) begin
                        if (!w_any) begin
                            r_db_cnt <= '0;
                            r_state  <= IDLE;
                        end else begin
                            // A different pattern restarts the stability count.
                            r_sample <= bus.d;
                            r_db_cnt <= DB_W'(1);
                        end
                    end else if (w_accept) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_code;
                        r_db_cnt    <= '0;
                        r_state     <= HELD;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    // No rollover: other keys are ignored until all lines drop.
                    if (!w_any) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    // Entry register: clear beats a coincident accept; a full entry flags overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd       <= '0;
            r_digit_cnt <= '0;
            r_overflow  <= 1'b0;
        end else if (bus.clr) begin
            r_bcd       <= '0;
            r_digit_cnt <= '0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            if (!w_full) begin
                r_bcd       <= w_shift;
                r_digit_cnt <= r_digit_cnt + CNT_W'(1);
            end else begin
`ifdef DECI_BCD_ROLL_EN
                r_bcd      <= w_shift;
`endif
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;
    assign bus.bcd_out   = r_bcd;
    assign bus.digit_cnt = r_digit_cnt;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_deci_bcd_keyenc.sv
// Bench for deci_bcd_keyenc: directed scenarios plus random key traffic against a run-length model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_deci_bcd_keyenc;

    localparam int ND  = 4;
    localparam int DC  = 4;
    localparam int EW  = 4 * ND;

    logic clk;
    logic rst;

    int checks  = 0;
    int errors  = 0;
    int kv_seen = 0;

    deci_bcd_keyenc_if #(.NUM_DIGITS(ND)) bus ();

    deci_bcd_keyenc #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Highest pressed key, or -1 when nothing is pressed.
    function automatic int hi_key(input logic [9:0] v);
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: a key is accepted on the edge where the current run of
    // identical nonzero samples reaches DC+1, provided no key has been accepted
    // since the lines last read all-zero.
    bit             m_armed   = 1'b1;
    int             m_run_len = 0;
    logic [9:0]     m_run_val = '0;
    logic           m_kv      = 1'b0;
    logic [3:0]     m_kc      = '0;
    logic [EW-1:0]  m_bcd     = '0;
    int             m_cnt     = 0;
    logic           m_ovf     = 1'b0;

    initial begin : model_and_compare
        logic       s_rst, s_clr, acc;
        logic [9:0] s_d;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_clr = bus.clr;
            s_d   = bus.d;
            if (s_rst) begin
                m_armed = 1'b1; m_run_len = 0; m_run_val = '0;
                m_kv = 1'b0; m_kc = '0; m_bcd = '0; m_cnt = 0; m_ovf = 1'b0;
            end else begin
                m_kv = 1'b0;
                if (s_d == 10'd0) begin
                    m_armed   = 1'b1;
                    m_run_len = 0;
                end else if (m_run_len > 0 && s_d == m_run_val) begin
                    m_run_len++;
                end else begin
                    m_run_val = s_d;
                    m_run_len = 1;
                end
                acc = m_armed && (s_d != 10'd0) && (m_run_len == DC + 1);
                if (acc) begin
                    m_armed = 1'b0;
                    m_kv    = 1'b1;
                    m_kc    = 4'(hi_key(s_d));
                end
                if (s_clr) begin
                    m_bcd = '0; m_cnt = 0; m_ovf = 1'b0;
                end else if (acc) begin
                    if (m_cnt < ND) begin
                        m_bcd = (m_bcd << 4) | EW'(m_kc);
                        m_cnt++;
                    end else begin
`ifdef DECI_BCD_ROLL_EN
                        m_bcd = (m_bcd << 4) | EW'(m_kc);
`endif
                        m_ovf = 1'b1;
                    end
                end
            end
            @(negedge clk);
            chk("key_valid", 32'(bus.key_valid), 32'(m_kv));
            chk("key_code",  32'(bus.key_code),  32'(m_kc));
            chk("bcd_out",   32'(bus.bcd_out),   32'(m_bcd));
            chk("digit_cnt", 32'(bus.digit_cnt), 32'(m_cnt));
            chk("full",      32'(bus.full),      32'(m_cnt == ND));
            chk("overflow",  32'(bus.overflow),  32'(m_ovf));
            if (bus.key_valid === 1'b1) kv_seen++;
        end
    end

    // Apply inputs, let one rising edge sample them, return shortly after it.
    task automatic cyc(input logic [9:0] dv, input logic cv, input logic rv);
        bus.d   = dv;
        bus.clr = cv;
        rst     = rv;
        @(posedge clk);
        #2;
    endtask

    task automatic key(input logic [9:0] dv, input int hold, input int gap);
        repeat (hold) cyc(dv, 1'b0, 1'b0);
        repeat (gap)  cyc(10'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [9:0] onehot(input int k);
        logic [9:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin : stimulus
        int base;
        bus.d   = '0;
        bus.clr = 1'b0;
        rst     = 1'b1;

        // Reset holds everything at zero even with every key pressed.
        repeat (3) begin
            cyc(10'h3FF, 1'b0, 1'b1);
            chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
            chk("rst_bcd_out",   32'(bus.bcd_out),   32'd0);
            chk("rst_digit_cnt", 32'(bus.digit_cnt), 32'd0);
            chk("rst_overflow",  32'(bus.overflow),  32'd0);
        end
        repeat (DC) cyc(10'h3FF, 1'b0, 1'b0);
        chk("rst_no_early_accept", 32'(bus.key_valid), 32'd0);
        cyc(10'h3FF, 1'b0, 1'b0);
        chk("rst_accept_valid", 32'(bus.key_valid), 32'd1);
        chk("rst_accept_code",  32'(bus.key_code),  32'd9);
        repeat (2) cyc(10'd0, 1'b0, 1'b0);
        cyc(10'd0, 1'b1, 1'b0);

        // Clean entry of 1, 2, 3.
        base = kv_seen;
        key(10'h002, 6, 2);
        key(10'h004, 6, 2);
        key(10'h008, 6, 2);
        chk("clean_pulses",    32'(kv_seen - base),  32'd3);
        chk("clean_bcd_out",   32'(bus.bcd_out),     32'h0123);
        chk("clean_digit_cnt", 32'(bus.digit_cnt),   32'd3);
        chk("clean_full",      32'(bus.full),        32'd0);

        // Bouncing key 4 is ignored until it settles.
        cyc(10'd0, 1'b1, 1'b0);
        base = kv_seen;
        for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? 10'h010 : 10'h000, 1'b0, 1'b0);
        chk("bounce_no_pulse", 32'(kv_seen - base), 32'd0);
        key(10'h010, 6, 2);
        chk("bounce_one_pulse", 32'(kv_seen - base), 32'd1);
        chk("bounce_code",      32'(bus.key_code),   32'd4);

        // Priority: highest pressed line wins.
        key(10'h201, 6, 2);
        chk("prio_9", 32'(bus.key_code), 32'd9);
        key(10'h006, 6, 2);
        chk("prio_2", 32'(bus.key_code), 32'd2);

        // Holding one key and sliding to another produces no second press.
        cyc(10'd0, 1'b1, 1'b0);
        base = kv_seen;
        repeat (5) cyc(10'h002, 1'b0, 1'b0);
        repeat (8) cyc(10'h008, 1'b0, 1'b0);
        repeat (2) cyc(10'h000, 1'b0, 1'b0);
        chk("held_pulses",  32'(kv_seen - base), 32'd1);
        chk("held_bcd_out", 32'(bus.bcd_out),    32'h0001);

        // Overfilling the entry.
        cyc(10'd0, 1'b1, 1'b0);
        for (int k = 5; k <= 9; k++) key(onehot(k), 6, 2);
`ifdef DECI_BCD_ROLL_EN
        chk("full_bcd_out", 32'(bus.bcd_out), 32'h6789);
`else
        chk("full_bcd_out", 32'(bus.bcd_out), 32'h5678);
`endif
        chk("full_overflow",  32'(bus.overflow),  32'd1);
        chk("full_digit_cnt", 32'(bus.digit_cnt), 32'd4);
        chk("full_full",      32'(bus.full),      32'd1);

        // Clear on the same edge as an accept of key 7.
        cyc(10'd0, 1'b1, 1'b0);
        key(10'h002, 6, 2);
        key(10'h004, 6, 2);
        chk("clr_pre_bcd", 32'(bus.bcd_out), 32'h0012);
        repeat (DC) cyc(10'h080, 1'b0, 1'b0);
        cyc(10'h080, 1'b1, 1'b0);
        chk("clr_acc_valid", 32'(bus.key_valid), 32'd1);
        chk("clr_acc_code",  32'(bus.key_code),  32'd7);
        chk("clr_acc_bcd",   32'(bus.bcd_out),   32'd0);
        chk("clr_acc_cnt",   32'(bus.digit_cnt), 32'd0);
        repeat (2) cyc(10'd0, 1'b0, 1'b0);

        // Random key traffic with occasional clear and reset.
        for (int n = 0; n < 400; n++) begin
            int         r, len, sel;
            logic [9:0] dv;
            r   = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            if (sel < 70)      dv = onehot($urandom_range(0, 9));
            else if (sel < 85) dv = 10'($urandom);
            else               dv = '0;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                cyc(dv, ($urandom_range(0, 39) == 0), (r < 2 && k == 0));
            end
        end
        repeat (3) cyc(10'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
